// File: rtl/time_date_setter_pkg.sv
// Shared types, field codes and BCD helpers for the time/date setter.
package time_set_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        EDIT_HOUR  = 3'd1,
        EDIT_MIN   = 3'd2,
        EDIT_SEC   = 3'd3,
        EDIT_DAY   = 3'd4,
        EDIT_MONTH = 3'd5,
        EDIT_YEAR  = 3'd6,
        COMMIT     = 3'd7
    } state_t;

    localparam logic [2:0] FLD_NONE  = 3'd0;
    localparam logic [2:0] FLD_HOUR  = 3'd1;
    localparam logic [2:0] FLD_MIN   = 3'd2;
    localparam logic [2:0] FLD_SEC   = 3'd3;
    localparam logic [2:0] FLD_DAY   = 3'd4;
    localparam logic [2:0] FLD_MONTH = 3'd5;
    localparam logic [2:0] FLD_YEAR  = 3'd6;

    localparam logic [7:0] HOUR_MAX   = 8'h23;
    localparam logic [7:0] MINSEC_MAX = 8'h59;
    localparam logic [7:0] DAY_MAX    = 8'h31;
    localparam logic [7:0] MONTH_MAX  = 8'h12;

    // BCD ordering matches binary ordering, so plain compares are safe here.
    function automatic logic [7:0] bcd2_inc(input logic [7:0] v, input logic [7:0] lo,
                                            input logic [7:0] hi);
        if (v >= hi) return lo;
        if (v[3:0] >= 4'd9) return {v[7:4] + 4'd1, 4'h0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd2_dec(input logic [7:0] v, input logic [7:0] lo,
                                            input logic [7:0] hi);
        if (v <= lo || v > hi) return hi;
        if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'h9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    // A two-digit BCD number is a multiple of 4 iff (even tens, ones 0/4/8) or (odd tens, ones 2/6).
    function automatic logic bcd2_div4(input logic [7:0] v);
        if (v[4]) return (v[3:0] == 4'd2) || (v[3:0] == 4'd6);
        return (v[3:0] == 4'd0) || (v[3:0] == 4'd4) || (v[3:0] == 4'd8);
    endfunction

    function automatic logic [7:0] days_in_month(input logic [7:0] month, input logic [15:0] year);
        logic leap;
        leap = (year[7:0] != 8'h00) ? bcd2_div4(year[7:0]) : bcd2_div4(year[15:8]);
        case (month)
            8'h02:                      return leap ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
            default:                    return 8'h31;
        endcase
    endfunction

endpackage

// File: rtl/time_date_setter_debouncer.sv
// Synchronizes and debounces one active-low pushbutton; emits a 1-cycle pulse per accepted press.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int DEB_W           = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic press
);

    localparam logic [DEB_W-1:0] CNT_LOAD = DEB_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic [DEB_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= CNT_LOAD;
            press <= 1'b0;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= CNT_LOAD;
            end else if (cnt == '0) begin
                // Terminal count reached: the new level has been stable long enough.
                level <= sync2;
                press <= ~sync2;
                cnt   <= CNT_LOAD;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/time_date_setter.sv
// Field-by-field time/date editor that loads a validated word into the calendar counter.
//   state      | meaning
//   IDLE       | waiting for change press; counter runs freely
//   EDIT_HOUR  | editing hour  (00..23)
//   EDIT_MIN   | editing minute (00..59)
//   EDIT_SEC   | editing second (00..59)
//   EDIT_DAY   | editing day   (01..31)
//   EDIT_MONTH | editing month (01..12)
//   EDIT_YEAR  | editing year  (0000..9999)
//   COMMIT     | day clamped, set_valid held until set_ready
module time_date_setter
    import time_set_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int DEB_W           = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        butt_change,
    input  logic        butt_increase,
    input  logic        butt_decrease,
    input  logic [23:0] cur_time,
    input  logic [31:0] cur_date,
    output logic        edit_active,
    output logic [2:0]  field_sel,
    output logic [23:0] edit_time,
    output logic [31:0] edit_date,
    output logic        set_valid,
    input  logic        set_ready
);

    logic   chg_p, inc_p, dec_p, step_en, year_carry;
    state_t state, next_state;
    logic [7:0] fld_cur, fld_lo, fld_hi, fld_next, year_hi_next, dim, day_clamped;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DEB_W(DEB_W)) u_deb_chg (
        .clk(clk), .rst(rst), .btn_n(butt_change), .press(chg_p));
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DEB_W(DEB_W)) u_deb_inc (
        .clk(clk), .rst(rst), .btn_n(butt_increase), .press(inc_p));
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DEB_W(DEB_W)) u_deb_dec (
        .clk(clk), .rst(rst), .btn_n(butt_decrease), .press(dec_p));

    assign step_en = (inc_p ^ dec_p) & ~chg_p;

    always_comb begin
        fld_cur    = 8'h00;
        fld_lo     = 8'h00;
        fld_hi     = 8'h00;
        next_state = IDLE;
        case (state)
            IDLE:       next_state = EDIT_HOUR;
            EDIT_HOUR:  begin fld_cur = edit_time[23:16]; fld_hi = HOUR_MAX;   next_state = EDIT_MIN;   end
            EDIT_MIN:   begin fld_cur = edit_time[15:8];  fld_hi = MINSEC_MAX; next_state = EDIT_SEC;   end
            EDIT_SEC:   begin fld_cur = edit_time[7:0];   fld_hi = MINSEC_MAX; next_state = EDIT_DAY;   end
            EDIT_DAY:   begin fld_cur = edit_date[31:24]; fld_lo = 8'h01; fld_hi = DAY_MAX;   next_state = EDIT_MONTH; end
            EDIT_MONTH: begin fld_cur = edit_date[23:16]; fld_lo = 8'h01; fld_hi = MONTH_MAX; next_state = EDIT_YEAR;  end
            EDIT_YEAR:  begin fld_cur = edit_date[7:0];   fld_hi = 8'h99;      next_state = COMMIT;     end
            default:    next_state = IDLE;
        endcase
        fld_next   = inc_p ? bcd2_inc(fld_cur, fld_lo, fld_hi) : bcd2_dec(fld_cur, fld_lo, fld_hi);
        // Year is two BCD pairs; the upper pair steps only when the lower pair wraps.
        year_carry = inc_p ? (edit_date[7:0] >= 8'h99) : (edit_date[7:0] == 8'h00);
        if (!year_carry)
            year_hi_next = edit_date[15:8];
        else if (inc_p)
            year_hi_next = bcd2_inc(edit_date[15:8], 8'h00, 8'h99);
        else
            year_hi_next = bcd2_dec(edit_date[15:8], 8'h00, 8'h99);
        dim         = days_in_month(edit_date[23:16], edit_date[15:0]);
        day_clamped = (edit_date[31:24] > dim) ? dim : edit_date[31:24];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            set_valid <= 1'b0;
            edit_time <= 24'h000000;
            edit_date <= 32'h0101_2024;
        end else begin
            case (state)
                IDLE: begin
                    if (chg_p) begin
                        edit_time <= cur_time;
                        edit_date <= cur_date;
                        state     <= next_state;
                    end
                end
                COMMIT: begin
                    if (set_ready) begin
                        set_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    if (chg_p) begin
                        state <= next_state;
                        if (state == EDIT_YEAR) begin
                            edit_date[31:24] <= day_clamped;
                            set_valid        <= 1'b1;
                        end
                    end else if (step_en) begin
                        case (state)
                            EDIT_HOUR:  edit_time[23:16] <= fld_next;
                            EDIT_MIN:   edit_time[15:8]  <= fld_next;
                            EDIT_SEC:   edit_time[7:0]   <= fld_next;
                            EDIT_DAY:   edit_date[31:24] <= fld_next;
                            EDIT_MONTH: edit_date[23:16] <= fld_next;
                            EDIT_YEAR:  edit_date[15:0]  <= {year_hi_next, fld_next};
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    assign edit_active = (state != IDLE);

    always_comb begin
        field_sel = FLD_NONE;
        case (state)
            EDIT_HOUR:  field_sel = FLD_HOUR;
            EDIT_MIN:   field_sel = FLD_MIN;
            EDIT_SEC:   field_sel = FLD_SEC;
            EDIT_DAY:   field_sel = FLD_DAY;
            EDIT_MONTH: field_sel = FLD_MONTH;
            EDIT_YEAR:  field_sel = FLD_YEAR;
            default:    field_sel = FLD_NONE;
        endcase
    end

endmodule
